// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: CPU load/store passes straight through when idle;
// a dump request stalls the CPU and streams every memory word over valid/ready.
module dmem_dump_arbiter #(
    parameter int N  = 64,
    parameter int AW = 6
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          dump,
    input  logic [N-1:0]  cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    input  logic          cpu_we,
    output logic [N-1:0]  cpu_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [N-1:0]  dump_data,
    output logic          dump_done
);

    // state | meaning
    // IDLE  | CPU owns the memory port, waiting for a dump rising edge
    // LOAD  | read word cnt from memory into data_q
    // VALID | present data_q / cnt to the consumer until dump_ready
    // DONE  | pass complete, hold dump_done until dump drops
    typedef enum logic [1:0] {IDLE, LOAD, VALID, DONE} st_t;

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    st_t           st;
    st_t           st_nxt;
    logic [AW-1:0] cnt;
    logic [N-1:0]  data_q;
    logic          dump_prev;
    logic          start;
    logic          unused_addr_bits;

    assign start            = dump & ~dump_prev;
    assign unused_addr_bits = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            data_q    <= '0;
            dump_prev <= 1'b0;
        end else begin
            dump_prev <= dump;
            if (st == LOAD) begin
                data_q <= mem_rdata;
            end
            if (st == VALID && dump_ready && cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (st == DONE && !dump) begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (start) st_nxt = LOAD;
            LOAD:    st_nxt = VALID;
            VALID:   if (dump_ready) st_nxt = (cnt == LAST) ? DONE : LOAD;
            DONE:    if (!dump) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // The CPU access in the start cycle still completes; stall begins next cycle.
    always_comb begin
        mem_addr   = cnt;
        mem_wdata  = cpu_wdata;
        mem_we     = 1'b0;
        cpu_rdata  = '0;
        cpu_stall  = 1'b1;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_addr  = cnt;
        dump_data  = data_q;
        case (st)
            IDLE: begin
                mem_addr  = cpu_addr[AW+2:3];
                mem_we    = cpu_we;
                cpu_rdata = mem_rdata;
                cpu_stall = 1'b0;
            end
            VALID:   dump_valid = 1'b1;
            DONE:    dump_done  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Directed bench for dmem_dump_arbiter with a behavioural 64-word memory.
module tb_dmem_dump_arbiter;

    localparam int N  = 64;
    localparam int AW = 6;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          dump;
    logic [N-1:0]  cpu_addr;
    logic [N-1:0]  cpu_wdata;
    logic          cpu_we;
    logic [N-1:0]  cpu_rdata;
    logic          cpu_stall;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          mem_we;
    logic [N-1:0]  mem_rdata;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [N-1:0]  dump_data;
    logic          dump_done;

    logic [N-1:0]  mem [0:63];
    logic          preload = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    dmem_dump_arbiter #(.N(N), .AW(AW)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .dump      (dump),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .dump_done (dump_done)
    );

    always @(posedge CLOCK_50) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'(i * 3);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_preload;
        preload = 1'b1;
        tick;
        preload = 1'b0;
    endtask

    task automatic wait_word(input int w, input string name);
        int n = 0;
        while (!(dump_valid === 1'b1 && dump_addr === 6'(w)) && n < 300) begin
            tick;
            n++;
        end
        checks++;
        if (!(dump_valid === 1'b1 && dump_addr === 6'(w))) begin
            errors++;
            $display("FAIL %s_wait: dump_addr=%0d valid=%b required addr=%0d valid=1", name, dump_addr, dump_valid, w);
        end
    endtask

    task automatic finish_pass(input string name);
        int n = 0;
        dump_ready = 1'b1;
        while (dump_done !== 1'b1 && n < 300) begin
            tick;
            n++;
        end
        checks++;
        if (dump_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: dump_done=%b required 1", name, dump_done);
        end
        dump = 1'b0;
        tick;
        checks++;
        if (cpu_stall !== 1'b0 || dump_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: stall=%b done=%b required 0 0", name, cpu_stall, dump_done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        checks++;
        if ({cpu_stall, dump_valid, dump_done, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: stall/valid/done/we=%b required 0000", {cpu_stall, dump_valid, dump_done, mem_we});
        end
        checks++;
        if (dump_data !== 64'd0 || dump_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_dump_regs: data=%h addr=%0d required 0 0", dump_data, dump_addr);
        end
        reset = 1'b1;
        tick;
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_start_after_release: stall=%b required 1", cpu_stall);
        end
        dump = 1'b0;
        finish_pass("reset");
    endtask

    task automatic test_cpu_pass;
        cpu_we    = 1'b1;
        cpu_addr  = 64'h18;
        cpu_wdata = 64'hDEAD;
        #1;
        checks++;
        if (mem_addr !== 6'd3 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL cpu_store: mem_addr=%0d we=%b required 3 1", mem_addr, mem_we);
        end
        tick;
        cpu_we = 1'b0;
        #1;
        checks++;
        if (cpu_rdata !== 64'hDEAD) begin
            errors++;
            $display("FAIL cpu_load: cpu_rdata=%h required dead", cpu_rdata);
        end
    endtask

    task automatic test_full_dump;
        int idx     = 0;
        int done_c  = 0;
        bit stall_ok = 1'b1;
        do_preload;
        dump_ready = 1'b1;
        dump = 1'b1;
        tick;
        dump = 1'b0;
        for (int c = 1; c <= 140 && done_c == 0; c++) begin
            tick;
            if (dump_done === 1'b1) done_c = c;
            if (cpu_stall !== 1'b1) stall_ok = 1'b0;
            if (dump_valid === 1'b1) begin
                checks++;
                if (dump_addr !== 6'(idx) || dump_data !== 64'(idx * 3)) begin
                    errors++;
                    $display("FAIL full_word: addr=%0d data=%0d required %0d %0d", dump_addr, dump_data, idx, idx * 3);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 64) begin
            errors++;
            $display("FAIL full_count: handshakes=%0d required 64", idx);
        end
        checks++;
        if (done_c != 128) begin
            errors++;
            $display("FAIL full_done_latency: cycles=%0d required 128", done_c);
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL full_stall: stall dropped=1 required 0");
        end
        tick;
        checks++;
        if (cpu_stall !== 1'b0 || dump_done !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: stall=%b done=%b required 0 0", cpu_stall, dump_done);
        end
    endtask

    task automatic test_backpressure;
        dump_ready = 1'b1;
        dump = 1'b1;
        tick;
        dump = 1'b0;
        wait_word(5, "bp");
        dump_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick;
            else #1;
            checks++;
            if (dump_valid !== 1'b1 || dump_data !== 64'd15 || dump_addr !== 6'd5) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d addr=%0d required 1 15 5", k, dump_valid, dump_data, dump_addr);
            end
        end
        dump_ready = 1'b1;
        tick;
        checks++;
        if (dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_load_gap: valid=%b required 0", dump_valid);
        end
        tick;
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 6'd6 || dump_data !== 64'd18) begin
            errors++;
            $display("FAIL bp_next: valid=%b addr=%0d data=%0d required 1 6 18", dump_valid, dump_addr, dump_data);
        end
        finish_pass("bp");
    endtask

    task automatic test_store_at_edge;
        cpu_we    = 1'b1;
        cpu_addr  = 64'h0;
        cpu_wdata = 64'hBEEF;
        dump      = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL edge_store: we=%b stall=%b required 1 0", mem_we, cpu_stall);
        end
        tick;
        cpu_we = 1'b0;
        dump   = 1'b0;
        cpu_we = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || cpu_stall !== 1'b1 || cpu_rdata !== 64'd0) begin
            errors++;
            $display("FAIL edge_stalled_we: we=%b stall=%b rdata=%h required 0 1 0", mem_we, cpu_stall, cpu_rdata);
        end
        cpu_we = 1'b0;
        tick;
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 6'd0 || dump_data !== 64'hBEEF) begin
            errors++;
            $display("FAIL edge_first_word: valid=%b addr=%0d data=%h required 1 0 beef", dump_valid, dump_addr, dump_data);
        end
        finish_pass("edge");
    endtask

    task automatic test_reset_mid_pass;
        dump_ready = 1'b1;
        dump = 1'b1;
        tick;
        dump = 1'b0;
        wait_word(20, "rst");
        reset = 1'b0;
        #1;
        checks++;
        if (dump_valid !== 1'b0 || cpu_stall !== 1'b0 || dump_addr !== 6'd0) begin
            errors++;
            $display("FAIL rst_immediate: valid=%b stall=%b addr=%0d required 0 0 0", dump_valid, cpu_stall, dump_addr);
        end
        tick;
        reset = 1'b1;
        tick;
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: stall=%b required 0", cpu_stall);
        end
        dump = 1'b1;
        tick;
        dump = 1'b0;
        tick;
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 6'd0 || dump_data !== 64'hBEEF) begin
            errors++;
            $display("FAIL rst_restart: valid=%b addr=%0d data=%h required 1 0 beef", dump_valid, dump_addr, dump_data);
        end
        finish_pass("rst");
    endtask

    initial begin
        reset      = 1'b1;
        dump       = 1'b1;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_we     = 1'b0;
        dump_ready = 1'b1;
        #2;
        test_reset;
        test_cpu_pass;
        test_full_dump;
        test_backpressure;
        test_store_at_edge;
        test_reset_mid_pass;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
